// File: rtl/regar_mp_pkg.sv
// Shared types and sizes for the multi-port address-register bank.
// Ports: none (package). Also hosts the shared sizes defaults.
// The `SIZE_* / `HBIT_* macros are only defined here when no earlier sizes include set them.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef HBIT_AR
`define HBIT_AR 7
`endif
`ifndef SIZE_AR_DELTA
`define SIZE_AR_DELTA 8
`endif

package regar_mp_pkg;

    localparam int LP_SIZE_ADDR     = `SIZE_ADDR;
    localparam int LP_NUM_AR        = `HBIT_AR + 1;
    localparam int LP_SIZE_AR_DELTA = `SIZE_AR_DELTA;

    // Index width with a floor of one bit so a single-entry bank still has an address.
    function automatic int aw_min1(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Where a read port's data comes from this cycle.
    typedef enum logic [1:0] {
        RD_SRC_NONE   = 2'd0,   // index outside the bank: reads as 0, not busy
        RD_SRC_REG    = 2'd1,   // stored register value
        RD_SRC_BYPASS = 2'd2    // port-A write data forwarded in the same cycle
    } rd_src_e;

endpackage

// File: rtl/regar_sb.sv
// Busy scoreboard: one pending bit per address register, set by claim, cleared by writeback.
// Ports: iw_clk/iw_rst, clear (writeback) enable+index, claim enable+index, busy_vec out.
// Registered output; a claim and a clear on the same index leave the bit set.
module regar_sb
    import regar_mp_pkg::*;
#(
    parameter int P_DEPTH = LP_NUM_AR,
    parameter int P_AW    = aw_min1(P_DEPTH)
) (
    input  logic               iw_clk,
    input  logic               iw_rst,
    input  logic               clr_en,
    input  logic [P_AW-1:0]    clr_addr,
    input  logic               claim_en,
    input  logic [P_AW-1:0]    claim_addr,
    output logic [P_DEPTH-1:0] busy_vec
);

    // Indices at or beyond P_DEPTH match no entry, so they drop out naturally.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            busy_vec <= '0;
        end else begin
            for (int k = 0; k < P_DEPTH; k++) begin
                // The claim belongs to the newer producer, so it outranks the clear.
                if (claim_en && (claim_addr == k[P_AW-1:0])) begin
                    busy_vec[k] <= 1'b1;
                end else if (clr_en && (clr_addr == k[P_AW-1:0])) begin
                    busy_vec[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/regar_mp.sv
// Multi-port address-register bank: P_NRD combinational reads, writeback port A,
// in-place signed post-increment port B, busy scoreboard and optional A->read bypass.
// Ports: iw_rd_addr/ow_rd_data/ow_rd_busy (packed per port), iw_wa_*, iw_wb_*, iw_claim_*,
// ow_busy_vec, ow_collide. Reads 0-cycle; writes land at posedge; no backpressure.
module regar_mp
    import regar_mp_pkg::*;
#(
    parameter int P_W      = LP_SIZE_ADDR,
    parameter int P_DEPTH  = LP_NUM_AR,
    parameter int P_AW     = aw_min1(P_DEPTH),
    parameter int P_NRD    = 2,
    parameter int P_DW     = LP_SIZE_AR_DELTA,
    parameter int P_BYPASS = 1
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst,
    input  logic [P_NRD*P_AW-1:0] iw_rd_addr,
    output logic [P_NRD*P_W-1:0]  ow_rd_data,
    output logic [P_NRD-1:0]      ow_rd_busy,
    input  logic                  iw_wa_en,
    input  logic [P_AW-1:0]       iw_wa_addr,
    input  logic [P_W-1:0]        iw_wa_data,
    input  logic                  iw_wb_en,
    input  logic [P_AW-1:0]       iw_wb_addr,
    input  logic [P_DW-1:0]       iw_wb_delta,
    input  logic                  iw_claim_en,
    input  logic [P_AW-1:0]       iw_claim_addr,
    output logic [P_DEPTH-1:0]    ow_busy_vec,
    output logic                  ow_collide
);

    logic [P_W-1:0]     r [P_DEPTH];
    logic [P_DEPTH-1:0] wa_sel;
    logic [P_DEPTH-1:0] wb_sel;
    logic [P_W-1:0]     wb_delta_ext;

    assign wb_delta_ext = P_W'($signed(iw_wb_delta));

    // One-hot write decode; an out-of-range index decodes to all zeros and is ignored.
    always_comb begin
        wa_sel = '0;
        wb_sel = '0;
        for (int k = 0; k < P_DEPTH; k++) begin
            wa_sel[k] = iw_wa_en && (iw_wa_addr == k[P_AW-1:0]);
            wb_sel[k] = iw_wb_en && (iw_wb_addr == k[P_AW-1:0]);
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            for (int k = 0; k < P_DEPTH; k++) begin
                r[k] <= '0;
            end
            ow_collide <= 1'b0;
        end else begin
            for (int k = 0; k < P_DEPTH; k++) begin
                // Writeback carries the architecturally newer value, so it beats the update.
                if (wa_sel[k]) begin
                    r[k] <= iw_wa_data;
                end else if (wb_sel[k]) begin
                    r[k] <= r[k] + wb_delta_ext;
                end
            end
            ow_collide <= |(wa_sel & wb_sel);
        end
    end

    regar_sb #(
        .P_DEPTH (P_DEPTH),
        .P_AW    (P_AW)
    ) u_sb (
        .iw_clk     (iw_clk),
        .iw_rst     (iw_rst),
        .clr_en     (iw_wa_en),
        .clr_addr   (iw_wa_addr),
        .claim_en   (iw_claim_en),
        .claim_addr (iw_claim_addr),
        .busy_vec   (ow_busy_vec)
    );

    for (genvar i = 0; i < P_NRD; i++) begin : g_rd
        logic [P_AW-1:0] addr;
        logic [P_W-1:0]  reg_dat;
        logic            reg_busy;
        logic            reg_hit;
        logic            byp;
        rd_src_e         src;
        logic [P_W-1:0]  dat;
        logic            busy;

        assign addr = iw_rd_addr[i*P_AW +: P_AW];
        // Only an in-range port-A write forwards; port B is never forwarded.
        assign byp  = (P_BYPASS != 0) && (|wa_sel) && (iw_wa_addr == addr);

        always_comb begin
            reg_dat  = '0;
            reg_busy = 1'b0;
            reg_hit  = 1'b0;
            for (int k = 0; k < P_DEPTH; k++) begin
                if (addr == k[P_AW-1:0]) begin
                    reg_hit  = 1'b1;
                    reg_dat  = r[k];
                    reg_busy = ow_busy_vec[k];
                end
            end

            if (byp) begin
                src = RD_SRC_BYPASS;
            end else if (reg_hit) begin
                src = RD_SRC_REG;
            end else begin
                src = RD_SRC_NONE;
            end

            dat  = '0;
            busy = 1'b0;
            case (src)
                RD_SRC_BYPASS: begin
                    dat  = iw_wa_data;
                    busy = 1'b0;
                end
                RD_SRC_REG: begin
                    dat  = reg_dat;
                    busy = reg_busy;
                end
                default: begin
                    dat  = '0;
                    busy = 1'b0;
                end
            endcase
        end

        assign ow_rd_data[i*P_W +: P_W] = dat;
        assign ow_rd_busy[i]            = busy;
    end

endmodule

// File: tb/tb_regar_mp.sv
// Bench for regar_mp: vector table for the main bank (8 x 16b, 2 read ports, bypass on),
// hand sequences for async reset, reset discard and a 3-deep bank with out-of-range indices.
// Registered outputs are expected via a queue pushed at drive time and popped after the edge.
module tb_regar_mp;

    localparam int W   = 16;
    localparam int D   = 8;
    localparam int AW  = 3;
    localparam int NRD = 2;
    localparam int DW  = 8;
    localparam int D3  = 3;
    localparam int AW3 = 2;

    logic iw_clk = 1'b0;
    logic iw_rst;
    always #5 iw_clk = ~iw_clk;

    // main bank
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*W-1:0]  rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              wa_en;
    logic [AW-1:0]     wa_addr;
    logic [W-1:0]      wa_data;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_delta;
    logic              cl_en;
    logic [AW-1:0]     cl_addr;
    logic [D-1:0]      busy_vec;
    logic              collide;

    // 3-deep bank
    logic [NRD*AW3-1:0] d3_rd_addr;
    logic [NRD*W-1:0]   d3_rd_data;
    logic [NRD-1:0]     d3_rd_busy;
    logic               d3_wa_en;
    logic [AW3-1:0]     d3_wa_addr;
    logic [W-1:0]       d3_wa_data;
    logic               d3_wb_en;
    logic [AW3-1:0]     d3_wb_addr;
    logic [DW-1:0]      d3_wb_delta;
    logic               d3_cl_en;
    logic [AW3-1:0]     d3_cl_addr;
    logic [D3-1:0]      d3_busy_vec;
    logic               d3_collide;

    regar_mp #(
        .P_W(W), .P_DEPTH(D), .P_AW(AW), .P_NRD(NRD), .P_DW(DW), .P_BYPASS(1)
    ) u_dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst),
        .iw_rd_addr(rd_addr), .ow_rd_data(rd_data), .ow_rd_busy(rd_busy),
        .iw_wa_en(wa_en), .iw_wa_addr(wa_addr), .iw_wa_data(wa_data),
        .iw_wb_en(wb_en), .iw_wb_addr(wb_addr), .iw_wb_delta(wb_delta),
        .iw_claim_en(cl_en), .iw_claim_addr(cl_addr),
        .ow_busy_vec(busy_vec), .ow_collide(collide)
    );

    regar_mp #(
        .P_W(W), .P_DEPTH(D3), .P_AW(AW3), .P_NRD(NRD), .P_DW(DW), .P_BYPASS(1)
    ) u_dut3 (
        .iw_clk(iw_clk), .iw_rst(iw_rst),
        .iw_rd_addr(d3_rd_addr), .ow_rd_data(d3_rd_data), .ow_rd_busy(d3_rd_busy),
        .iw_wa_en(d3_wa_en), .iw_wa_addr(d3_wa_addr), .iw_wa_data(d3_wa_data),
        .iw_wb_en(d3_wb_en), .iw_wb_addr(d3_wb_addr), .iw_wb_delta(d3_wb_delta),
        .iw_claim_en(d3_cl_en), .iw_claim_addr(d3_cl_addr),
        .ow_busy_vec(d3_busy_vec), .ow_collide(d3_collide)
    );

    typedef struct {
        logic        wa_en;
        logic [2:0]  wa_addr;
        logic [15:0] wa_data;
        logic        wb_en;
        logic [2:0]  wb_addr;
        logic [7:0]  wb_delta;
        logic        cl_en;
        logic [2:0]  cl_addr;
        logic [2:0]  rd0;
        logic [2:0]  rd1;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        b0;
        logic        b1;
        logic        col;    // ow_collide after the edge
        logic [7:0]  busy;   // ow_busy_vec after the edge
    } vec_t;

    typedef struct {
        logic       col;
        logic [7:0] busy;
    } post_t;

    localparam int NV = 21;
    vec_t  vecs [NV];
    post_t post_q [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_delta = '0;
        cl_en = 1'b0; cl_addr = '0;
        rd_addr = '0;
        d3_wa_en = 1'b0; d3_wa_addr = '0; d3_wa_data = '0;
        d3_wb_en = 1'b0; d3_wb_addr = '0; d3_wb_delta = '0;
        d3_cl_en = 1'b0; d3_cl_addr = '0;
        d3_rd_addr = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        post_t exp_post;

        // wa_en wa_addr wa_data | wb_en wb_addr delta | cl_en cl_addr | rd0 rd1 | d0 d1 b0 b1 | col busy
        vecs[0]  = '{1'b1,3'd2,16'h1234, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd2,3'd2, 16'h1234,16'h1234,1'b0,1'b0, 1'b0,8'h00};
        vecs[1]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd2,3'd2, 16'h1234,16'h1234,1'b0,1'b0, 1'b0,8'h00};
        vecs[2]  = '{1'b1,3'd1,16'h0010, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd1,3'd0, 16'h0010,16'h0000,1'b0,1'b0, 1'b0,8'h00};
        vecs[3]  = '{1'b0,3'd0,16'h0000, 1'b1,3'd1,8'hFC, 1'b0,3'd0, 3'd1,3'd2, 16'h0010,16'h1234,1'b0,1'b0, 1'b0,8'h00};
        vecs[4]  = '{1'b0,3'd0,16'h0000, 1'b1,3'd1,8'h08, 1'b0,3'd0, 3'd1,3'd2, 16'h000C,16'h1234,1'b0,1'b0, 1'b0,8'h00};
        vecs[5]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd1,3'd0, 16'h0014,16'h0000,1'b0,1'b0, 1'b0,8'h00};
        vecs[6]  = '{1'b1,3'd1,16'hFFFF, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd1,3'd1, 16'hFFFF,16'hFFFF,1'b0,1'b0, 1'b0,8'h00};
        vecs[7]  = '{1'b0,3'd0,16'h0000, 1'b1,3'd1,8'h01, 1'b0,3'd0, 3'd1,3'd2, 16'hFFFF,16'h1234,1'b0,1'b0, 1'b0,8'h00};
        vecs[8]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd1,3'd3, 16'h0000,16'h0000,1'b0,1'b0, 1'b0,8'h00};
        vecs[9]  = '{1'b1,3'd3,16'h0005, 1'b1,3'd3,8'h01, 1'b0,3'd0, 3'd3,3'd3, 16'h0005,16'h0005,1'b0,1'b0, 1'b1,8'h00};
        vecs[10] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd3,3'd1, 16'h0005,16'h0000,1'b0,1'b0, 1'b0,8'h00};
        vecs[11] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,8'h00, 1'b1,3'd0, 3'd0,3'd3, 16'h0000,16'h0005,1'b0,1'b0, 1'b0,8'h01};
        vecs[12] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd0,3'd1, 16'h0000,16'h0000,1'b1,1'b0, 1'b0,8'h01};
        vecs[13] = '{1'b1,3'd0,16'hABCD, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd0,3'd0, 16'hABCD,16'hABCD,1'b0,1'b0, 1'b0,8'h00};
        vecs[14] = '{1'b1,3'd0,16'h1111, 1'b0,3'd0,8'h00, 1'b1,3'd0, 3'd0,3'd2, 16'h1111,16'h1234,1'b0,1'b0, 1'b0,8'h01};
        vecs[15] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd0,3'd2, 16'h1111,16'h1234,1'b1,1'b0, 1'b0,8'h01};
        vecs[16] = '{1'b0,3'd0,16'h0000, 1'b1,3'd5,8'h80, 1'b1,3'd5, 3'd5,3'd0, 16'h0000,16'h1111,1'b0,1'b1, 1'b0,8'h21};
        vecs[17] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd5,3'd1, 16'hFF80,16'h0000,1'b1,1'b0, 1'b0,8'h21};
        vecs[18] = '{1'b1,3'd5,16'h0042, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd5,3'd0, 16'h0042,16'h1111,1'b0,1'b1, 1'b0,8'h01};
        vecs[19] = '{1'b1,3'd6,16'h0600, 1'b1,3'd2,8'h01, 1'b0,3'd0, 3'd2,3'd6, 16'h1234,16'h0600,1'b0,1'b0, 1'b0,8'h01};
        vecs[20] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd2,3'd6, 16'h1235,16'h0600,1'b0,1'b0, 1'b0,8'h01};

        // Reset state, released mid-cycle.
        iw_rst = 1'b1;
        idle_inputs();
        rd_addr = {3'd2, 3'd7};
        #1;
        chk("reset rd0", 32'(rd_data[15:0]), 32'h0);
        chk("reset rd1", 32'(rd_data[31:16]), 32'h0);
        chk("reset busy_vec", 32'(busy_vec), 32'h0);
        chk("reset collide", 32'(collide), 32'h0);
        #11;
        iw_rst = 1'b0;

        // Vector table.
        for (int v = 0; v < NV; v++) begin
            @(negedge iw_clk);
            wa_en    = vecs[v].wa_en;
            wa_addr  = vecs[v].wa_addr;
            wa_data  = vecs[v].wa_data;
            wb_en    = vecs[v].wb_en;
            wb_addr  = vecs[v].wb_addr;
            wb_delta = vecs[v].wb_delta;
            cl_en    = vecs[v].cl_en;
            cl_addr  = vecs[v].cl_addr;
            rd_addr  = {vecs[v].rd1, vecs[v].rd0};
            post_q.push_back('{vecs[v].col, vecs[v].busy});
            #1;
            chk($sformatf("v%0d rd0_dat", v), 32'(rd_data[15:0]), 32'(vecs[v].d0));
            chk($sformatf("v%0d rd1_dat", v), 32'(rd_data[31:16]), 32'(vecs[v].d1));
            chk($sformatf("v%0d rd0_busy", v), 32'(rd_busy[0]), 32'(vecs[v].b0));
            chk($sformatf("v%0d rd1_busy", v), 32'(rd_busy[1]), 32'(vecs[v].b1));
            @(posedge iw_clk);
            #1;
            exp_post = post_q.pop_front();
            chk($sformatf("v%0d collide", v), 32'(collide), 32'(exp_post.col));
            chk($sformatf("v%0d busy_vec", v), 32'(busy_vec), 32'(exp_post.busy));
        end

        // Collision pulse, then async reset asserted mid-cycle while it is high.
        @(negedge iw_clk);
        idle_inputs();
        wa_en = 1'b1; wa_addr = 3'd4; wa_data = 16'h0001;
        wb_en = 1'b1; wb_addr = 3'd4; wb_delta = 8'h01;
        @(posedge iw_clk);
        #1;
        chk("pre-reset collide", 32'(collide), 32'h1);
        idle_inputs();
        rd_addr = {3'd0, 3'd5};
        #2;
        iw_rst = 1'b1;
        #1;
        chk("async reset rd r5", 32'(rd_data[15:0]), 32'h0);
        chk("async reset rd r0", 32'(rd_data[31:16]), 32'h0);
        chk("async reset busy_vec", 32'(busy_vec), 32'h0);
        chk("async reset collide", 32'(collide), 32'h0);

        // In-flight write and claim while reset is held are discarded.
        @(negedge iw_clk);
        wa_en = 1'b1; wa_addr = 3'd4; wa_data = 16'h7777;
        cl_en = 1'b1; cl_addr = 3'd4;
        rd_addr = {3'd3, 3'd3};
        @(posedge iw_clk);
        #1;
        chk("held reset busy_vec", 32'(busy_vec), 32'h0);
        chk("held reset rd r3", 32'(rd_data[15:0]), 32'h0);
        @(negedge iw_clk);
        #2;
        iw_rst = 1'b0;
        idle_inputs();
        rd_addr = {3'd4, 3'd4};
        #1;
        chk("post-reset r4 discarded", 32'(rd_data[15:0]), 32'h0);
        chk("post-reset busy4", 32'(rd_busy[1]), 32'h0);
        // First write after release is accepted on the next posedge.
        wa_en = 1'b1; wa_addr = 3'd4; wa_data = 16'h0099;
        cl_en = 1'b1; cl_addr = 3'd4;
        @(posedge iw_clk);
        #1;
        idle_inputs();
        rd_addr = {3'd3, 3'd4};
        #1;
        chk("first write r4", 32'(rd_data[15:0]), 32'h0099);
        chk("first claim busy r4", 32'(rd_busy[0]), 32'h1);
        chk("first claim busy_vec", 32'(busy_vec), 32'h10);

        // 3-deep bank: index 3 is out of range for writes, claims, updates and reads.
        @(negedge iw_clk);
        idle_inputs();
        d3_wa_en = 1'b1; d3_wa_addr = 2'd3; d3_wa_data = 16'h5555;
        d3_wb_en = 1'b1; d3_wb_addr = 2'd3; d3_wb_delta = 8'h01;
        d3_cl_en = 1'b1; d3_cl_addr = 2'd3;
        d3_rd_addr = {2'd2, 2'd3};
        #1;
        chk("d3 oor same-cycle rd", 32'(d3_rd_data[15:0]), 32'h0);
        chk("d3 oor same-cycle busy", 32'(d3_rd_busy[0]), 32'h0);
        @(posedge iw_clk);
        #1;
        chk("d3 oor busy_vec", 32'(d3_busy_vec), 32'h0);
        chk("d3 oor collide", 32'(d3_collide), 32'h0);
        chk("d3 oor rd after", 32'(d3_rd_data[15:0]), 32'h0);
        chk("d3 r2 untouched", 32'(d3_rd_data[31:16]), 32'h0);
        @(negedge iw_clk);
        idle_inputs();
        d3_wa_en = 1'b1; d3_wa_addr = 2'd2; d3_wa_data = 16'h0ABC;
        @(negedge iw_clk);
        idle_inputs();
        d3_cl_en = 1'b1; d3_cl_addr = 2'd2;
        @(negedge iw_clk);
        idle_inputs();
        d3_rd_addr = {2'd3, 2'd2};
        #1;
        chk("d3 r2 data", 32'(d3_rd_data[15:0]), 32'h0ABC);
        chk("d3 r2 busy", 32'(d3_rd_busy[0]), 32'h1);
        chk("d3 oor rd busy", 32'(d3_rd_busy[1]), 32'h0);
        chk("d3 busy_vec", 32'(d3_busy_vec), 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
